// File: rtl/score_pkg.sv
// Shared types, glyph geometry and BCD helper for the score display block.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int GLYPH_W    = 8;
  localparam int GLYPH_H    = 16;
  localparam int MAX_DIGITS = 5;

  // Decimal +1 over the low nd digits; an all-9s value is returned unchanged.
  function automatic logic [4*MAX_DIGITS-1:0] bcd_inc(
    input logic [4*MAX_DIGITS-1:0] v,
    input int                      nd
  );
    logic [4*MAX_DIGITS-1:0] r;
    logic                    carry;
    logic                    all9;
    r     = v;
    carry = 1'b1;
    all9  = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < nd) begin
        if (v[4*i +: 4] != 4'd9) all9 = 1'b0;
        if (carry) begin
          if (v[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = v[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return all9 ? v : r;
  endfunction

endpackage

// File: rtl/digits_rom.sv
// 8x16 seven-segment style digit font; address = digit*16 + row, bit 7 is the leftmost column.
module digits_rom (
  input  logic [7:0] addr,
  output logic [7:0] data
);

  logic [6:0] seg;
  logic [3:0] row;

  always_comb begin
    row = addr[3:0];
    // Segment order gfedcba.
    case (addr[7:4])
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
    data = 8'h00;
    if (row < 4'd2)
      data = seg[0] ? 8'h7E : 8'h00;
    else if (row < 4'd7)
      data = (seg[5] ? 8'hC0 : 8'h00) | (seg[1] ? 8'h03 : 8'h00);
    else if (row < 4'd9)
      data = seg[6] ? 8'h7E : 8'h00;
    else if (row < 4'd14)
      data = (seg[4] ? 8'hC0 : 8'h00) | (seg[2] ? 8'h03 : 8'h00);
    else
      data = seg[3] ? 8'h7E : 8'h00;
  end

endmodule

// File: rtl/score_keeper_field.sv
// Renders one NUM_DIGITS-wide BCD field at a fixed screen position; one glyph ROM shared by all slots.
module score_keeper_field
  import score_pkg::*;
#(
  parameter int         NUM_DIGITS = 3,
  parameter int         SCALE      = 3,
  parameter logic [9:0] FIELD_X    = 10'd0,
  parameter logic [9:0] FIELD_Y    = 10'd0
) (
  input  logic [9:0]              draw_x,
  input  logic [9:0]              draw_y,
  input  logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    lit
);

  localparam logic [11:0] FIELD_W  = 12'(NUM_DIGITS * GLYPH_W * SCALE);
  localparam logic [11:0] FIELD_H  = 12'(GLYPH_H * SCALE);
  localparam logic [11:0] SCALE_W  = 12'(SCALE);
  localparam int          COL_BITS = $clog2(GLYPH_W);

  logic [11:0]           dx;
  logic [11:0]           dy;
  logic [11:0]           gx;
  logic [3:0]            gy;
  logic [11:0]           slot;
  logic [COL_BITS-1:0]   col;
  logic                  in_box;
  logic [NUM_DIGITS-1:0] shown;
  logic [3:0]            sel_digit;
  logic                  sel_shown;
  logic [7:0]            rom_data;

  always_comb begin
    dx     = {2'b00, draw_x} - {2'b00, FIELD_X};
    dy     = {2'b00, draw_y} - {2'b00, FIELD_Y};
    in_box = (draw_x >= FIELD_X) && (draw_y >= FIELD_Y) && (dx < FIELD_W) && (dy < FIELD_H);
    gx     = dx / SCALE_W;
    gy     = 4'(dy / SCALE_W);
    slot   = gx >> COL_BITS;
    col    = gx[COL_BITS-1:0];
  end

  // Leading-zero blanking: a digit is drawn if it or any more significant digit is nonzero.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++)
      shown[i] = (i == 0) || ((bcd >> (4 * i)) != '0);
  end

  // Slot 0 is the leftmost glyph, i.e. the most significant digit.
  always_comb begin
    sel_digit = 4'd0;
    sel_shown = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (slot == 12'(NUM_DIGITS - 1 - i)) begin
        sel_digit = bcd[4*i +: 4];
        sel_shown = shown[i];
      end
    end
  end

  digits_rom u_rom (
    .addr ({sel_digit, gy}),
    .data (rom_data)
  );

  assign lit = in_box && sel_shown && rom_data[~col];

endmodule

// File: rtl/score_keeper.sv
// Run score counter with high-score tracking, record blink and on-screen BCD rendering.
module score_keeper
  import score_pkg::*;
#(
  parameter int         NUM_DIGITS  = 3,
  parameter int         UNIT_FRAMES = 30,
  parameter int         SCALE       = 3,
  parameter logic [9:0] SCORE_X     = 10'd560,
  parameter logic [9:0] SCORE_Y     = 10'd10,
  parameter logic [9:0] HI_X        = 10'd560,
  parameter logic [9:0] HI_Y        = 10'd60,
  parameter int         BLINK_TICKS = 8
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    frame_tick,
  input  logic                    playing,
  input  logic [9:0]              DrawX,
  input  logic [9:0]              DrawY,
  output logic                    is_score,
  output logic                    is_hiscore,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic [4*NUM_DIGITS-1:0] hiscore_bcd,
  output logic                    new_record
);

  localparam int SCORE_W = 4 * NUM_DIGITS;

  state_t                  state;
  state_t                  state_nxt;
  logic                    enter_run;
  logic                    enter_over;
  logic [7:0]              prescaler;
  logic                    unit_done;
  logic [4*MAX_DIGITS-1:0] score_wide;
  logic [SCORE_W-1:0]      score_inc;
  logic [7:0]              blink_cnt;
  logic                    blink_off;
  logic                    score_lit;
  logic                    hi_lit;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    enter_run  = 1'b0;
    enter_over = 1'b0;
    case (state)
      IDLE:    if (playing)  state_nxt = RUN;
      RUN:     if (!playing) state_nxt = OVER;
      OVER:    if (playing)  state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    enter_run  = (state != RUN) && (state_nxt == RUN);
    enter_over = (state == RUN) && (state_nxt == OVER);
  end

  assign unit_done = (prescaler == 8'(UNIT_FRAMES - 1));

  always_comb begin
    score_wide              = '0;
    score_wide[SCORE_W-1:0] = score_bcd;
    score_inc               = SCORE_W'(bcd_inc(score_wide, NUM_DIGITS));
  end

  // A tick coinciding with the end of the run is dropped.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      score_bcd <= '0;
      prescaler <= '0;
    end else if (enter_run) begin
      score_bcd <= '0;
      prescaler <= '0;
    end else if ((state == RUN) && !enter_over && frame_tick) begin
      if (unit_done) begin
        prescaler <= '0;
        score_bcd <= score_inc;
      end else begin
        prescaler <= prescaler + 8'd1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hiscore_bcd <= '0;
      new_record  <= 1'b0;
      blink_cnt   <= '0;
      blink_off   <= 1'b0;
    end else if (enter_run) begin
      new_record <= 1'b0;
    end else if (enter_over) begin
      if (score_bcd > hiscore_bcd) begin
        hiscore_bcd <= score_bcd;
        new_record  <= 1'b1;
        blink_cnt   <= '0;
        blink_off   <= 1'b0;
      end
    end else if (new_record && frame_tick) begin
      if (blink_cnt == 8'(BLINK_TICKS - 1)) begin
        blink_cnt <= '0;
        blink_off <= ~blink_off;
      end else begin
        blink_cnt <= blink_cnt + 8'd1;
      end
    end
  end

  score_keeper_field #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCALE      (SCALE),
    .FIELD_X    (SCORE_X),
    .FIELD_Y    (SCORE_Y)
  ) u_score_field (
    .draw_x (DrawX),
    .draw_y (DrawY),
    .bcd    (score_bcd),
    .lit    (score_lit)
  );

  score_keeper_field #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCALE      (SCALE),
    .FIELD_X    (HI_X),
    .FIELD_Y    (HI_Y)
  ) u_hi_field (
    .draw_x (DrawX),
    .draw_y (DrawY),
    .bcd    (hiscore_bcd),
    .lit    (hi_lit)
  );

  assign is_score   = score_lit;
  assign is_hiscore = hi_lit && !score_lit && !(new_record && blink_off);

endmodule
